// File: rtl/ccff_pkg.sv
// ccff_pkg: shared FSM state type and bit-serial CRC-8 helpers for the configuration-chain loader
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READBACK,
        ST_DONE
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One bit-serial CRC-8 step: feedback is the outgoing MSB xored with the new bit
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// ccff_crc8: serial CRC-8 register with synchronous clear and per-bit enable
module ccff_crc8
    import ccff_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_d;
    logic [7:0] crc_q;

    // Clear wins over a shift so a new operation always starts from the init value
    always_comb begin
        crc_d = clr ? CRC8_INIT : (en ? crc8_step(crc_q, bit_in) : crc_q);
    end

    // CRC state register
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) crc_q <= CRC8_INIT;
        else         crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream words LSB-first into a configuration chain, or recirculates it for readback, with CRC-8
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 67,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              mode,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              cfg_shift_en,
    output logic              busy,
    output logic              done,
    output logic [7:0]        crc
);

    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              crc_clr;
    logic              crc_bit;
    logic              word_end;
    logic              last_cnt;
    logic              last_shift;

    assign word_end   = buf_valid_q && (idx_q == IDX_LAST);
    assign last_cnt   = (cnt_q == CNT_LAST);
    assign last_shift = cfg_shift_en && last_cnt;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

    // FSM state register; reset aborts any operation without a done pulse
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state: start is only honoured in IDLE, both operations end on the final counted shift
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:              if (start) state_d = mode ? ST_READBACK : ST_LOAD;
            ST_LOAD, ST_READBACK: if (last_shift) state_d = ST_DONE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Outputs: LOAD shifts only while a word is buffered, READBACK recirculates tail to head
    always_comb begin
        s_ready      = 1'b0;
        ccff_head    = 1'b0;
        cfg_shift_en = 1'b0;
        crc_bit      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                cfg_shift_en = buf_valid_q;
                ccff_head    = buf_q[idx_q];
                crc_bit      = buf_q[idx_q];
                s_ready      = !buf_valid_q || (word_end && !last_cnt);
            end
            ST_READBACK: begin
                cfg_shift_en = 1'b1;
                ccff_head    = ccff_tail;
                crc_bit      = ccff_tail;
            end
            default: ;
        endcase
    end

    // Datapath: word buffer, bit index and shift counter; refill on the last bit of a word avoids bubbles
    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        crc_clr     = 1'b0;
        if (state_q == ST_IDLE && start) begin
            buf_valid_d = 1'b0;
            idx_d       = '0;
            cnt_d       = '0;
            crc_clr     = 1'b1;
        end
        if (cfg_shift_en && !last_cnt) cnt_d = cnt_q + 1'b1;
        if (state_q == ST_LOAD && cfg_shift_en) begin
            idx_d       = (word_end || last_cnt) ? '0 : idx_q + 1'b1;
            buf_valid_d = !word_end && !last_cnt;
        end
        if (s_valid && s_ready) begin
            buf_d       = s_data;
            buf_valid_d = 1'b1;
            idx_d       = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    ccff_crc8 u_crc8 (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (crc_clr),
        .en       (cfg_shift_en),
        .bit_in   (crc_bit),
        .crc      (crc)
    );

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: randomized bench with a behavioural chain model and polynomial-division CRC reference
module tb_ccff_loader;

    localparam int CL = 67;
    localparam int W  = 8;

    typedef bit         bitq_t[$];
    typedef logic [7:0] wq_t[$];

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b0;
    logic          start    = 1'b0;
    logic          mode     = 1'b0;
    logic          s_valid  = 1'b0;
    logic [W-1:0]  s_data   = '0;
    logic          s_ready, ccff_head, ccff_tail, cfg_shift_en, busy, done;
    logic [7:0]    crc;
    logic [CL-1:0] chain = '0;
    logic          preset_req = 1'b0;

    bitq_t head_q, tail_q;
    int    sh_cyc[$];
    int    cyc = 0;
    int    n_done = 0;
    int    n_chk = 0;
    int    n_err = 0;
    int    base_sh = 0;
    int    base_done = 0;

    ccff_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .mode         (mode),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .cfg_shift_en (cfg_shift_en),
        .busy         (busy),
        .done         (done),
        .crc          (crc)
    );

    always #5 prog_clk = ~prog_clk;

    // The external configuration chain: head enters at bit 0, tail leaves from the top bit
    assign ccff_tail = chain[CL-1];
    always @(posedge prog_clk) begin
        if (preset_req)        chain <= '1;
        else if (cfg_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end

    // Monitor sampled mid-cycle
    always @(negedge prog_clk) begin
        cyc++;
        if (cfg_shift_en) begin
            head_q.push_back(ccff_head);
            tail_q.push_back(ccff_tail);
            sh_cyc.push_back(cyc);
        end
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1, first bit highest degree
    function automatic logic [7:0] crc_ref(input bitq_t b);
        bitq_t m;
        logic [8:0] p;
        logic [7:0] r;
        p = 9'h107;
        m = b;
        repeat (8) m.push_back(1'b0);
        for (int i = 0; i < b.size(); i++)
            if (m[i]) for (int j = 0; j <= 8; j++) m[i+j] = m[i+j] ^ p[8-j];
        for (int j = 0; j < 8; j++) r[7-j] = m[b.size()+j];
        return r;
    endfunction

    function automatic bitq_t exp_bits(input wq_t w);
        bitq_t q;
        for (int i = 0; i < CL; i++) q.push_back(w[i/W][i%W]);
        return q;
    endfunction

    function automatic logic [CL-1:0] chain_of(input bitq_t e);
        logic [CL-1:0] v;
        for (int i = 0; i < CL; i++) v[CL-1-i] = e[i];
        return v;
    endfunction

    function automatic int seq_bad(input bitq_t got, input int base, input bitq_t e);
        int bad = 0;
        for (int i = 0; i < e.size(); i++)
            if (base + i >= got.size() || got[base+i] != e[i]) bad++;
        return bad;
    endfunction

    task automatic mark();
        base_sh   = head_q.size();
        base_done = n_done;
    endtask

    task automatic op_start(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge prog_clk); #1;
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic do_load(input wq_t w, input int gap_after, input int gap_len,
                           input bit rnd, input bit poke, input int abort_at);
        int k = 0;
        int gap = 0;
        int t = 0;
        logic acc;
        mark();
        op_start(1'b0);
        s_data  = w[0];
        s_valid = 1'b1;
        while (n_done == base_done && t < 400) begin
            @(negedge prog_clk);
            acc = s_valid && s_ready;
            @(posedge prog_clk); #1;
            t++;
            if (acc) begin
                k++;
                if (k == gap_after) gap = gap_len;
            end
            s_valid = (k < w.size()) && (gap == 0) && (!rnd || $urandom_range(0, 3) != 0);
            if (gap > 0) gap--;
            s_data = (k < w.size()) ? w[k] : '0;
            start  = poke && ((head_q.size() - base_sh == 20) || done);
            mode   = poke;
            if (abort_at >= 0 && head_q.size() - base_sh == abort_at) begin
                pReset = 1'b0;
                #1;
                check("abort_outs", {s_ready, ccff_head, cfg_shift_en, busy, done}, 5'b0);
                check("abort_crc", crc, 8'h00);
                repeat (3) @(posedge prog_clk);
                #1;
                check("abort_no_done", n_done - base_done, 0);
                check("abort_no_shift", head_q.size() - base_sh, abort_at);
                pReset = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        if (abort_at < 0) check("load_timeout", t < 400, 1'b1);
    endtask

    task automatic chk_load(input string tag, input wq_t w);
        bitq_t e;
        e = exp_bits(w);
        check({tag, "_nshift"}, head_q.size() - base_sh, CL);
        check({tag, "_seq"}, seq_bad(head_q, base_sh, e), 0);
        check({tag, "_done"}, n_done - base_done, 1);
        check({tag, "_crc"}, crc, crc_ref(e));
        check({tag, "_chain"}, chain, chain_of(e));
    endtask

    task automatic rb_check(input string tag, input bitq_t e);
        int t = 0;
        mark();
        op_start(1'b1);
        while (n_done == base_done && t < 400) begin
            @(posedge prog_clk); #1;
            t++;
        end
        check({tag, "_timeout"}, t < 400, 1'b1);
        check({tag, "_nshift"}, head_q.size() - base_sh, CL);
        check({tag, "_span"}, sh_cyc[sh_cyc.size()-1] - sh_cyc[base_sh] + 1, CL);
        check({tag, "_tail"}, seq_bad(tail_q, base_sh, e), 0);
        check({tag, "_done"}, n_done - base_done, 1);
        check({tag, "_crc"}, crc, crc_ref(e));
        check({tag, "_chain"}, chain, chain_of(e));
    endtask

    initial begin
        wq_t   w;
        bitq_t e;
        repeat (3) @(posedge prog_clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", s_ready, 1'b0);
        check("rst_shift", cfg_shift_en, 1'b0);
        check("rst_head", ccff_head, 1'b0);
        check("rst_crc", crc, 8'h00);
        pReset = 1'b1;
        @(posedge prog_clk); #1;

        w = {};
        repeat (9) w.push_back(8'h00);
        do_load(w, 0, 0, 1'b0, 1'b0, -1);
        chk_load("zero", w);
        check("zero_span", sh_cyc[sh_cyc.size()-1] - sh_cyc[base_sh] + 1, CL);
        check("zero_crc0", crc, 8'h00);

        w = {};
        repeat (8) w.push_back(8'hA5);
        w.push_back(8'h05);
        e = exp_bits(w);
        do_load(w, 0, 0, 1'b0, 1'b0, -1);
        chk_load("a5", w);
        rb_check("a5_rb", e);

        do_load(w, 3, 5, 1'b0, 1'b1, -1);
        chk_load("gap5", w);
        repeat (4) @(posedge prog_clk);
        #1;
        check("poke_idle", busy, 1'b0);
        check("poke_noshift", head_q.size() - base_sh, CL);
        check("poke_onedone", n_done - base_done, 1);

        do_load(w, 3, 12, 1'b0, 1'b0, -1);
        chk_load("gap12", w);
        check("gap12_stall", (sh_cyc[sh_cyc.size()-1] - sh_cyc[base_sh] + 1) > CL, 1'b1);

        w = {};
        repeat (9) w.push_back(8'($urandom));
        do_load(w, 0, 0, 1'b0, 1'b0, 30);
        @(posedge prog_clk); #1;
        w = {};
        repeat (9) w.push_back(8'($urandom));
        do_load(w, 0, 0, 1'b0, 1'b0, -1);
        chk_load("post_rst", w);

        preset_req = 1'b1;
        @(posedge prog_clk); #1;
        preset_req = 1'b0;
        e = {};
        repeat (CL) e.push_back(1'b1);
        rb_check("ones_rb", e);

        for (int it = 0; it < 4; it++) begin
            w = {};
            repeat (9) w.push_back(8'($urandom));
            e = exp_bits(w);
            do_load(w, 0, 0, 1'b1, 1'b0, -1);
            chk_load("rnd", w);
            rb_check("rnd_rb", e);
        end

        repeat (2) @(posedge prog_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
